// File: rtl/present_round_engine_pkg.sv
// Shared constants and FSM encoding for the PRESENT-80 round engine.
package present_round_engine_pkg;

   localparam int DATA_W         = 64;   // cipher block width
   localparam int PRESENT_ROUNDS = 31;   // full rounds before final whitening
   localparam int PRESENT_KEY_W  = 80;   // only the 80-bit key schedule exists
   localparam int RC_W           = 5;    // round counter width, 1..31

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_FIN  = 2'd2,
      ST_DONE = 2'd3
   } state_t;

endpackage

// File: rtl/present_key_sched_80.sv
// Combinational PRESENT-80 key update: rotate left 61, S-box the top nibble,
// XOR the round counter into bits 19:15.
module present_key_sched_80
   import present_round_engine_pkg::*;
(
   input  logic [PRESENT_KEY_W-1:0] key_cur,
   input  logic [RC_W-1:0]          rc,
   output logic [PRESENT_KEY_W-1:0] key_next
);

   logic [PRESENT_KEY_W-1:0] rot;
   logic [3:0]               top_sub;

   // Rotating left by 61 equals rotating right by 19.
   assign rot = {key_cur[18:0], key_cur[79:19]};

   SBox u_key_sbox (
      .x (rot[79:76]),
      .y (top_sub)
   );

   assign key_next = {top_sub, rot[75:20], rot[19:15] ^ rc, rot[14:0]};

endmodule

// File: rtl/present_round_engine_sbox.sv
// PRESENT 4-bit S-box and the 64-bit substitution layer built from 16 copies.
module SBox (
   input  logic [3:0] x,
   output logic [3:0] y
);

   // PRESENT S-box: C56B90AD3EF84712
   always_comb begin
      y = 4'h0;
      case (x)
         4'h0: y = 4'hC;
         4'h1: y = 4'h5;
         4'h2: y = 4'h6;
         4'h3: y = 4'hB;
         4'h4: y = 4'h9;
         4'h5: y = 4'h0;
         4'h6: y = 4'hA;
         4'h7: y = 4'hD;
         4'h8: y = 4'h3;
         4'h9: y = 4'hE;
         4'hA: y = 4'hF;
         4'hB: y = 4'h8;
         4'hC: y = 4'h4;
         4'hD: y = 4'h7;
         4'hE: y = 4'h1;
         default: y = 4'h2;
      endcase
   end

endmodule

module SubsLayer (
   input  logic [63:0] din,
   output logic [63:0] dout
);

   for (genvar n = 0; n < 16; n++) begin : g_nib
      SBox u_sbox (
         .x (din[4*n +: 4]),
         .y (dout[4*n +: 4])
      );
   end

endmodule

// File: rtl/present_round_engine.sv
// Iterative PRESENT-80 encryption core: one round per clock, key schedule
// running alongside, valid/ready handshakes on both sides.
module present_round_engine
   import present_round_engine_pkg::*;
#(
   parameter int ROUNDS = PRESENT_ROUNDS,
   parameter int KEY_W  = PRESENT_KEY_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] plaintext,
   input  logic [KEY_W-1:0]  key,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] ciphertext,
   output logic              busy
);

   state_t            st, st_nxt;
   logic [DATA_W-1:0] state_reg;
   logic [KEY_W-1:0]  key_reg;
   logic [RC_W-1:0]   rc;

   logic [DATA_W-1:0] t_add;
   logic [DATA_W-1:0] u_sub;
   logic [DATA_W-1:0] p_perm;
   logic [KEY_W-1:0]  key_next;

   // addRoundKey with the current round key (top 64 bits of the key register)
   assign t_add = state_reg ^ key_reg[KEY_W-1:KEY_W-DATA_W];

   SubsLayer u_subs (
      .din  (t_add),
      .dout (u_sub)
   );

   // pLayer is pure wiring: bit i moves to (16*i) mod 63, bit 63 stays put
   for (genvar i = 0; i < DATA_W - 1; i++) begin : g_perm
      assign p_perm[(16 * i) % 63] = u_sub[i];
   end
   assign p_perm[DATA_W-1] = u_sub[DATA_W-1];

   present_key_sched_80 u_ksched (
      .key_cur  (key_reg),
      .rc       (rc),
      .key_next (key_next)
   );

   // FSM state register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) st <= ST_IDLE;
      else       st <= st_nxt;
   end

   // Next-state decode; the last round is the one carrying rc == ROUNDS
   always_comb begin
      st_nxt = st;
      case (st)
         ST_IDLE: if (in_valid)                  st_nxt = ST_RUN;
         ST_RUN:  if (rc == RC_W'(ROUNDS))       st_nxt = ST_FIN;
         ST_FIN:                                 st_nxt = ST_DONE;
         ST_DONE: if (out_ready)                 st_nxt = ST_IDLE;
         default:                                st_nxt = ST_IDLE;
      endcase
   end

   // Datapath: inputs are only looked at on accept, so X outside accept stays out
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg  <= '0;
         key_reg    <= '0;
         rc         <= '0;
         ciphertext <= '0;
      end else begin
         case (st)
            ST_IDLE: begin
               if (in_valid) begin
                  state_reg <= plaintext;
                  key_reg   <= key;
                  rc        <= RC_W'(1);
               end
            end
            ST_RUN: begin
               state_reg <= p_perm;
               key_reg   <= key_next;
               // counter saturates at the last round rather than wrapping
               if (rc != RC_W'(ROUNDS)) rc <= rc + RC_W'(1);
            end
            ST_FIN: begin
               // final whitening with K32
               ciphertext <= t_add;
            end
            default: ;
         endcase
      end
   end

   assign in_ready  = (st == ST_IDLE);
   assign out_valid = (st == ST_DONE);
   assign busy      = (st == ST_RUN) || (st == ST_FIN);

endmodule

// File: tb/tb_present_round_engine.sv
// Self-checking bench for present_round_engine: known-answer vectors,
// randomized vectors against an algorithmic PRESENT-80 model, backpressure,
// input changes during the run and an asynchronous reset mid-operation.
module tb_present_round_engine;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [63:0] plaintext;
   logic [79:0] key;
   logic        out_valid;
   logic        out_ready;
   logic [63:0] ciphertext;
   logic        busy;

   int compared   = 0;
   int mismatched = 0;

   int sb [16] = '{12, 5, 6, 11, 9, 0, 10, 13, 3, 14, 15, 8, 4, 7, 1, 2};

   present_round_engine dut (
      .clk        (clk),
      .reset      (reset),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .plaintext  (plaintext),
      .key        (key),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .ciphertext (ciphertext),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   // PRESENT-80 encryption written directly from the cipher description
   function automatic logic [63:0] present_ref(input logic [63:0] pt, input logic [79:0] k);
      logic [63:0] s, sub, perm;
      logic [79:0] kk;
      int dst;
      s  = pt;
      kk = k;
      for (int r = 1; r <= 31; r++) begin
         s = s ^ kk[79:16];
         for (int n = 0; n < 16; n++) sub[4*n +: 4] = 4'(sb[int'(s[4*n +: 4])]);
         for (int b = 0; b < 64; b++) begin
            dst = (b == 63) ? 63 : (b * 16) % 63;
            perm[dst] = sub[b];
         end
         s  = perm;
         kk = (kk << 61) | (kk >> 19);
         kk[79:76] = 4'(sb[int'(kk[79:76])]);
         kk[19:15] = kk[19:15] ^ 5'(r);
      end
      return s ^ kk[79:16];
   endfunction

   task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [79:0] rand_key();
      return {16'($urandom), $urandom, $urandom};
   endfunction

   // Offer one block, scramble the inputs during the run, hold the result
   // for 'hold' cycles under backpressure, then take it.
   task automatic run_vec(input string tag, input logic [63:0] pt, input logic [79:0] k,
                          input logic [63:0] exp, input int hold);
      int guard;
      int lat;
      guard = 0;
      while (!in_ready && guard < 100) begin
         @(posedge clk); #1;
         guard++;
      end
      check({tag, ".in_ready_before"}, 80'(in_ready), 80'(1));
      plaintext = pt;
      key       = k;
      in_valid  = 1'b1;
      @(posedge clk); #1;
      in_valid  = 1'b0;
      plaintext = {$urandom, $urandom};
      key       = rand_key();
      check({tag, ".busy_run"}, 80'(busy), 80'(1));
      check({tag, ".in_ready_run"}, 80'(in_ready), 80'(0));
      lat = 0;
      while (!out_valid && lat < 40) begin
         @(posedge clk); #1;
         lat++;
         if (lat == 5)  out_ready = 1'b1;   // must be ignored while running
         if (lat == 10) out_ready = 1'b0;
         if (lat == 15) begin
            plaintext = {$urandom, $urandom};
            key       = rand_key();
            in_valid  = 1'b1;               // must be ignored while running
         end
         if (lat == 16) in_valid = 1'b0;
      end
      check({tag, ".latency"}, 80'(lat), 80'(32));
      check({tag, ".ciphertext"}, 80'(ciphertext), 80'(exp));
      check({tag, ".busy_done"}, 80'(busy), 80'(0));
      for (int h = 0; h < hold; h++) begin
         in_valid  = 1'b1;
         plaintext = {$urandom, $urandom};
         @(posedge clk); #1;
         check({tag, ".hold_valid"}, 80'(out_valid), 80'(1));
         check({tag, ".hold_ct"}, 80'(ciphertext), 80'(exp));
         check({tag, ".hold_in_ready"}, 80'(in_ready), 80'(0));
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      check({tag, ".taken_valid"}, 80'(out_valid), 80'(0));
      check({tag, ".taken_in_ready"}, 80'(in_ready), 80'(1));
      check({tag, ".taken_ct_kept"}, 80'(ciphertext), 80'(exp));
   endtask

   initial begin
      logic [63:0] rpt;
      logic [79:0] rk;
      reset     = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      plaintext = '0;
      key       = '0;
      @(posedge clk); #1;
      check("reset.in_ready", 80'(in_ready), 80'(1));
      check("reset.out_valid", 80'(out_valid), 80'(0));
      check("reset.busy", 80'(busy), 80'(0));
      check("reset.ciphertext", 80'(ciphertext), 80'(0));
      reset = 1'b0;
      @(posedge clk); #1;

      // Known-answer vectors
      run_vec("kat1", 64'h0, 80'h0, 64'h5579C1387B228445, 0);
      run_vec("kat2", 64'h0, {80{1'b1}}, 64'hE72C46C0F5945049, 1);
      run_vec("kat3", {64{1'b1}}, 80'h0, 64'hA112FFC72F68417B, 2);
      run_vec("kat4", {64{1'b1}}, {80{1'b1}}, 64'h3333DCD3213210D2, 10);

      // Randomized vectors against the model
      for (int v = 0; v < 5; v++) begin
         rpt = {$urandom, $urandom};
         rk  = rand_key();
         run_vec($sformatf("rnd%0d", v), rpt, rk, present_ref(rpt, rk), int'($urandom_range(0, 3)));
      end

      // Asynchronous reset in the middle of round 15
      plaintext = {$urandom, $urandom};
      key       = rand_key();
      in_valid  = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (15) @(posedge clk);
      #2 reset = 1'b1;
      #1;
      check("midreset.busy", 80'(busy), 80'(0));
      check("midreset.in_ready", 80'(in_ready), 80'(1));
      check("midreset.out_valid", 80'(out_valid), 80'(0));
      check("midreset.ciphertext", 80'(ciphertext), 80'(0));
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk); #1;
      check("midreset.no_output", 80'(out_valid), 80'(0));
      run_vec("after_reset", 64'h0, 80'h0, 64'h5579C1387B228445, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
